// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Sequencing and set-mode controller for the BCD time-of-day counter
//   chain. Divides clk down to a 1 s tick, issues single-cycle increment
//   strobes to the seconds/minutes/hours counters (cascading on their
//   terminal-count flags), and runs a RUN / SET_HOUR / SET_MIN mode FSM
//   driven by two pre-debounced key pulses. Owns no time digits itself.
//
// Parameters
//   TICK_DIV  clk cycles per 1 s tick (>= 2)
//   PS_W      prescaler width, derived from TICK_DIV
//
// Ports
//   clk       system clock, rising edge
//   rstn      asynchronous active-low reset
//   key_mode  single-cycle pulse, advances the mode
//   key_inc   single-cycle pulse, increments the selected field in set modes
//   sec_tc    seconds counter at 59 (level)
//   min_tc    minutes counter at 59 (level)
//   sec_en    one-cycle increment strobe, seconds counter
//   min_en    one-cycle increment strobe, minutes counter
//   hour_en   one-cycle increment strobe, hours counter
//   sec_clr   one-cycle synchronous clear, seconds counter
//   mode      00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blink     display blink phase for the selected field
//
// Every output comes straight from a flop; there is no input-to-output
// combinational path.

module clock_set_ctrl #(
  parameter  int TICK_DIV = 50000000,
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            sec_en_q,  sec_en_d;
  logic            min_en_q,  min_en_d;
  logic            hour_en_q, hour_en_d;
  logic            sec_clr_q, sec_clr_d;
  logic            blink_q,   blink_d;

  logic            term;
  logic            leave_set;

  // Terminal cycle of the 1 s prescaler.
  assign term = (ps_q == PS_MAX);

  // Leaving SET_MIN for RUN re-phases the tick so the first second after
  // setting is a full second long.
  assign leave_set = (state_q == SET_MIN) && key_mode;

  // --------------------------------------------------------------------
  // Prescaler: free-running in every state, reloaded on return to RUN.
  // --------------------------------------------------------------------
  always_comb begin
    ps_d = ps_q + 1'b1;
    if (term || leave_set) ps_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ps_q <= '0;
    else       ps_q <= ps_d;
  end

  // --------------------------------------------------------------------
  // Mode FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------
  // Mode FSM: next state
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (key_mode) state_d = SET_HOUR;
      SET_HOUR: if (key_mode) state_d = SET_MIN;
      SET_MIN:  if (key_mode) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // --------------------------------------------------------------------
  // Mode FSM: outputs (next values of the output flops)
  // key_mode always takes priority: a mode change swallows both a
  // coincident key_inc and a coincident tick.
  // --------------------------------------------------------------------
  always_comb begin
    sec_en_d  = 1'b0;
    min_en_d  = 1'b0;
    hour_en_d = 1'b0;
    sec_clr_d = 1'b0;
    blink_d   = blink_q;
    unique case (state_q)
      RUN: begin
        if (key_mode) begin
          blink_d = 1'b1;
        end else begin
          blink_d = 1'b0;
          if (term) begin
            sec_en_d  = 1'b1;
            min_en_d  = sec_tc;
            hour_en_d = sec_tc & min_tc;
          end
        end
      end
      SET_HOUR: begin
        if (key_mode) begin
          blink_d = 1'b1;
        end else begin
          hour_en_d = key_inc;
          if (term) blink_d = ~blink_q;
        end
      end
      SET_MIN: begin
        if (key_mode) begin
          blink_d   = 1'b0;
          sec_clr_d = 1'b1;
        end else begin
          // No carry into hours while the minutes are being set.
          min_en_d = key_inc;
          if (term) blink_d = ~blink_q;
        end
      end
      default: blink_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sec_en_q  <= 1'b0;
      min_en_q  <= 1'b0;
      hour_en_q <= 1'b0;
      sec_clr_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      sec_en_q  <= sec_en_d;
      min_en_q  <= min_en_d;
      hour_en_q <= hour_en_d;
      sec_clr_q <= sec_clr_d;
      blink_q   <= blink_d;
    end
  end

  assign sec_en  = sec_en_q;
  assign min_en  = min_en_q;
  assign hour_en = hour_en_q;
  assign sec_clr = sec_clr_q;
  assign blink   = blink_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: directed walk through the set/run flow plus
// randomized key/flag traffic, all compared against a phase-arithmetic
// reference model every cycle.
module tb_clock_set_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_mode = 1'b0, key_inc = 1'b0, sec_tc = 1'b0, min_tc = 1'b0;
  logic       sec_en, min_en, hour_en, sec_clr, blink;
  logic [1:0] mode;

  clock_set_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rstn(rstn), .key_mode(key_mode), .key_inc(key_inc),
    .sec_tc(sec_tc), .min_tc(min_tc), .sec_en(sec_en), .min_en(min_en),
    .hour_en(hour_en), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the tick phase is derived from the cycle count since
  // the last time-base anchor (reset release or return to RUN).
  int cyc, anchor, m_mode;
  bit m_blink, e_sec, e_min, e_hour, e_clr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; anchor = 0; m_mode = 0; m_blink = 0;
    e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
  endtask

  task automatic check_all();
    chk("mode",    32'(mode),    32'(m_mode));
    chk("sec_en",  32'(sec_en),  32'(e_sec));
    chk("min_en",  32'(min_en),  32'(e_min));
    chk("hour_en", 32'(hour_en), 32'(e_hour));
    chk("sec_clr", 32'(sec_clr), 32'(e_clr));
    chk("blink",   32'(blink),   32'(m_blink));
  endtask

  function automatic bit at_term();
    return ((cyc - anchor) % TD) == TD - 1;
  endfunction

  // Called just after a negedge: drive inputs, predict the next cycle,
  // clock once, check on the following negedge.
  task automatic step(input bit km, input bit ki, input bit stc, input bit mtc);
    bit term;
    key_mode = km; key_inc = ki; sec_tc = stc; min_tc = mtc;
    term = at_term();
    e_sec = 0; e_min = 0; e_hour = 0; e_clr = 0;
    if (km) begin
      m_mode = (m_mode + 1) % 3;
      m_blink = (m_mode != 0);
      if (m_mode == 0) begin
        e_clr  = 1;
        anchor = cyc + 1;
      end
    end else begin
      case (m_mode)
        0: begin
          m_blink = 0;
          if (term) begin e_sec = 1; e_min = stc; e_hour = stc & mtc; end
        end
        1: begin e_hour = ki; if (term) m_blink = !m_blink; end
        default: begin e_min = ki; if (term) m_blink = !m_blink; end
      endcase
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input bit stc, input bit mtc);
    for (int i = 0; i < n; i++) step(0, 0, stc, mtc);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();                       // outputs while held in reset
    rstn = 1'b1;
    model_reset();
    check_all();

    // 1. free run
    idle(10, 0, 0);
    // 2. cascade, then seconds-only carry
    idle(TD, 1, 1);
    idle(2, 0, 0);
    idle(TD, 1, 0);
    idle(2, 0, 0);
    // 3. set hours: 3 key_inc pulses spaced 2 cycles
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    idle(5, 0, 0);
    // 4. set minutes with min_tc held: no hour carry
    step(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin step(0, 1, 1, 1); step(0, 0, 1, 1); end
    idle(3, 1, 1);
    // 5. back to RUN
    step(1, 0, 0, 0);
    idle(2 * TD + 1, 0, 0);
    // 6. collisions
    step(1, 0, 0, 0);                  // RUN -> SET_HOUR
    step(1, 1, 0, 0);                  // key_mode wins -> SET_MIN, no hour_en
    step(1, 0, 0, 0);                  // -> RUN
    idle(1, 0, 0);
    while (!at_term()) step(0, 0, 1, 1);
    step(1, 0, 1, 1);                  // key_mode at terminal: tick dropped
    step(1, 0, 0, 0);                  // -> SET_MIN
    step(0, 1, 0, 0);                  // min_en due next cycle
    chk("min_en_before_rst", 32'(min_en), 32'(1));
    // asynchronous reset mid-SET_MIN with a strobe high
    key_inc = 1'b0;
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    check_all();

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
